pdh_cmd_dispatch: RTL and testbench

PDH_CMD_DISPATCH -- requirements
Module: pdh_cmd_dispatch

---
 rtl/pdh_cmd_dispatch.sv | 225 ++++++++++++++++++++++
 tb/tb_pdh_cmd_dispatch.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdh_cmd_dispatch.sv
// PS-to-PL command dispatcher: synchronizes a GPIO command word, pulses one
// function module, waits for its done/callback or a timeout, reports status.
module pdh_cmd_dispatch #(
  parameter int NUM_MODULES    = 4,
  parameter int CB_WIDTH       = 8,
  parameter int DATA_BITS      = 27,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_ni,
  input  logic [31:0]                     gpio_in_i,
  output logic [31:0]                     gpio_out_o,
  output logic [NUM_MODULES-1:0]          en_o,
  output logic [DATA_BITS-1:0]            data_o,
  input  logic [NUM_MODULES-1:0]          done_i,
  input  logic [NUM_MODULES*CB_WIDTH-1:0] cb_i,
  output logic                            busy_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [3:0] CMD_STROBE = 4'd14;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISP,
    S_WAIT
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_DONE,
    RES_TMO,
    RES_BAD
  } res_t;

  logic [31:0]            r_s1;
  logic [31:0]            r_s2;
  logic [3:0]             r_prev_cmd;
  logic [1:0]             r_rdy;
  logic [3:0]             r_stg_cmd;
  logic [DATA_BITS-1:0]   r_stg_pay;
  state_t                 r_state;
  logic                   r_busy;
  logic [NUM_MODULES-1:0] r_tgt;
  logic [NUM_MODULES-1:0] r_en;
  logic [DATA_BITS-1:0]   r_data;
  logic [3:0]             r_last_cmd;
  logic [CB_WIDTH-1:0]    r_cb;
  res_t                   r_res;
  logic                   r_ovr;
  logic [7:0]             r_seq;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_soft;
  logic [3:0]             w_cmd;
  logic                   w_strobe_edge;
  logic [NUM_MODULES-1:0] w_stg_oh;
  logic                   w_stg_ok;
  logic                   w_done;
  logic [CB_WIDTH-1:0]    w_cb_sel;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic                   w_tmo;
  logic [7:0]             w_cb8;
  state_t                 w_state_nxt;
  logic                   w_go;
  logic                   w_idle_res;
  logic                   w_fin_done;
  logic                   w_fin_tmo;
  logic                   w_ovr_set;

  assign w_soft    = r_s2[31];
  assign w_cmd     = r_s2[30:27];
  // r_rdy masks the false edge seen when STROBE is held through reset
  assign w_strobe_edge = (r_rdy == 2'd3) &&
                         (w_cmd == CMD_STROBE) &&
                         (r_prev_cmd != CMD_STROBE);
  assign w_stg_ok  = |w_stg_oh;
  assign w_done    = |(done_i & r_tgt);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_tmo     = (w_cnt_inc == CNT_LAST);
  assign w_cb8     = 8'(r_cb);

  always_comb begin
    w_stg_oh = '0;
    for (int k = 0; k < NUM_MODULES; k++)
      w_stg_oh[k] = (r_stg_cmd == 4'(k + 1));
  end

  always_comb begin
    w_cb_sel = '0;
    for (int k = 0; k < NUM_MODULES; k++)
      if (r_tgt[k])
        w_cb_sel = w_cb_sel | cb_i[k*CB_WIDTH +: CB_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_prev_cmd <= '0;
      r_rdy      <= '0;
    end else begin
      r_s1       <= gpio_in_i;
      r_s2       <= r_s1;
      r_prev_cmd <= w_cmd;
      if (r_rdy != 2'd3)
        r_rdy <= r_rdy + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_idle_res  = 1'b0;
    w_fin_done  = 1'b0;
    w_fin_tmo   = 1'b0;
    w_ovr_set   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_strobe_edge && w_stg_ok) begin
          w_state_nxt = S_DISP;
          w_go        = 1'b1;
        end else if (w_strobe_edge) begin
          w_idle_res  = 1'b1;
        end
      end
      S_DISP: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_done) begin
          w_state_nxt = S_IDLE;
          w_fin_done  = 1'b1;
        end else if (w_tmo) begin
          w_state_nxt = S_IDLE;
          w_fin_tmo   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (r_state != S_IDLE)
      w_ovr_set = w_strobe_edge;
    if (w_soft) begin
      w_state_nxt = S_IDLE;
      w_go        = 1'b0;
      w_idle_res  = 1'b0;
      w_fin_done  = 1'b0;
      w_fin_tmo   = 1'b0;
      w_ovr_set   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stg_cmd  <= '0;
      r_stg_pay  <= '0;
      r_tgt      <= '0;
      r_en       <= '0;
      r_data     <= '0;
      r_last_cmd <= '0;
      r_cb       <= '0;
      r_res      <= RES_NONE;
      r_ovr      <= 1'b0;
      r_seq      <= '0;
      r_cnt      <= '0;
    end else if (w_soft) begin
      r_stg_cmd  <= '0;
      r_stg_pay  <= '0;
      r_tgt      <= '0;
      r_en       <= '0;
      r_data     <= '0;
      r_last_cmd <= '0;
      r_cb       <= '0;
      r_res      <= RES_NONE;
      r_ovr      <= 1'b0;
      r_seq      <= '0;
      r_cnt      <= '0;
    end else begin
      r_en <= w_go ? w_stg_oh : '0;
      if (w_go)
        r_tgt <= w_stg_oh;
      if (w_idle_res)
        r_res <= (r_stg_cmd == 4'd0) ? RES_NONE : RES_BAD;
      if (r_state == S_DISP) begin
        r_data     <= r_stg_pay;
        r_last_cmd <= r_stg_cmd;
        r_cnt      <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_fin_done) begin
        r_cb  <= w_cb_sel;
        r_res <= RES_DONE;
        r_seq <= r_seq + 8'd1;
      end
      if (w_fin_tmo) begin
        r_cb  <= '0;
        r_res <= RES_TMO;
      end
      if (w_ovr_set)
        r_ovr <= 1'b1;
      if (w_cmd != CMD_STROBE) begin
        r_stg_cmd <= w_cmd;
        r_stg_pay <= r_s2[DATA_BITS-1:0];
      end
    end
  end

  assign en_o   = r_en;
  assign data_o = r_data;
  assign busy_o = r_busy;
  assign gpio_out_o = {4'b0, r_seq, r_ovr, r_busy, r_res,
                       w_cmd, r_last_cmd, w_cb8};

endmodule

// File: tb/tb_pdh_cmd_dispatch.sv
// Randomized bench for pdh_cmd_dispatch against a job-age reference model,
// plus directed scenarios with hand-computed status words.
module tb_pdh_cmd_dispatch;
  localparam int N   = 4;
  localparam int CBW = 8;
  localparam int DB  = 27;
  localparam int T   = 16;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic [31:0]      gpio_in = '0;
  logic [31:0]      gpio_out;
  logic [N-1:0]     en;
  logic [DB-1:0]    data;
  logic [N-1:0]     done = '0;
  logic [N*CBW-1:0] cb = '0;
  logic             busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pdh_cmd_dispatch #(
    .NUM_MODULES(N), .CB_WIDTH(CBW),
    .DATA_BITS(DB), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_ni(rst_ni),
    .gpio_in_i(gpio_in), .gpio_out_o(gpio_out),
    .en_o(en), .data_o(data),
    .done_i(done), .cb_i(cb), .busy_o(busy)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: a job is described only by its age in
  // cycles since acceptance.
  logic [31:0] m_s1, m_s2;
  logic [3:0]  m_prev;
  int          m_edges;
  logic [3:0]  m_stg_cmd;
  logic [26:0] m_stg_pay;
  bit          m_job;
  int          m_age, m_tgt;
  logic [3:0]  m_en;
  logic [26:0] m_data;
  logic [3:0]  m_last;
  logic [7:0]  m_cb, m_seq;
  logic [1:0]  m_res;
  bit          m_ovr;
  logic [31:0] mv_s2;
  bit          mv_edge;
  int          mv_c;

  task automatic model_clear();
    m_stg_cmd = '0; m_stg_pay = '0;
    m_job = 1'b0; m_age = 0; m_tgt = 0;
    m_en = '0; m_data = '0; m_last = '0;
    m_cb = '0; m_seq = '0; m_res = '0;
    m_ovr = 1'b0;
  endtask

  task automatic model_step();
    mv_s2 = m_s2;
    m_edges++;
    mv_edge = (mv_s2[30:27] == 4'd14) &&
              (m_prev != 4'd14) && (m_edges >= 4);
    m_en = '0;
    if (mv_s2[31]) begin
      model_clear();
    end else begin
      if (m_job) begin
        if (mv_edge) m_ovr = 1'b1;
        m_age++;
        if (m_age == 1) begin
          m_data = m_stg_pay;
          m_last = m_stg_cmd;
        end else if (done[m_tgt]) begin
          m_cb  = cb[m_tgt*CBW +: CBW];
          m_res = 2'd1;
          m_seq = m_seq + 8'd1;
          m_job = 1'b0;
        end else if (m_age == T) begin
          m_res = 2'd2;
          m_cb  = '0;
          m_job = 1'b0;
        end
      end else if (mv_edge) begin
        mv_c = int'(m_stg_cmd);
        if (mv_c >= 1 && mv_c <= N) begin
          m_job = 1'b1;
          m_age = 0;
          m_tgt = mv_c - 1;
          m_en  = 4'(1 << (mv_c - 1));
        end else begin
          m_res = (mv_c == 0) ? 2'd0 : 2'd3;
        end
      end
      if (mv_s2[30:27] != 4'd14) begin
        m_stg_cmd = mv_s2[30:27];
        m_stg_pay = mv_s2[26:0];
      end
    end
    m_prev = mv_s2[30:27];
    m_s2   = m_s1;
    m_s1   = gpio_in;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_ni);
    if (!rst_ni) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_edges = 0;
      model_clear();
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cyc_en", 32'(en), 32'(m_en));
      chk("cyc_data", 32'(data), 32'(m_data));
      chk("cyc_busy", 32'(busy), 32'(m_job));
      chk("cyc_gpo", gpio_out,
          {4'b0, m_seq, m_ovr, m_job, m_res,
           m_s2[30:27], m_last, m_cb});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rtick(input int n);
    repeat (n) begin
      @(negedge clk);
      done = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
      cb   = $urandom;
    end
  endtask

  task automatic wr(input logic [3:0] c, input logic [26:0] p);
    gpio_in = {1'b0, c, p};
  endtask

  task automatic wait_en(output logic [3:0] seen);
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (en != '0) begin
        seen = en;
        break;
      end
    end
  endtask

  logic [3:0] seen;
  int         nb, np, c;

  initial begin
    gpio_in = {1'b0, 4'd14, 27'd0};
    tick(2);
    chk("rst_gpo", gpio_out, 32'h0);
    chk("rst_en", 32'(en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_data", 32'(data), 32'h0);
    rst_ni = 1'b1;
    chk_en = 1'b1;
    repeat (4) begin
      tick(1);
      chk("rel_no_en", 32'(en), 32'h0);
    end
    wr(4'd0, 27'd0);
    tick(3);

    wr(4'd2, 27'h55);
    tick(4);
    wr(4'd14, 27'h55);
    wait_en(seen);
    chk("t1_en", 32'(seen), 32'h2);
    wr(4'd0, 27'd0);
    tick(1);
    chk("t1_en_once", 32'(en), 32'h0);
    chk("t1_data", 32'(data), 32'h55);
    tick(3);
    done = 4'b0010;
    cb   = {8'h11, 8'h22, 8'hA5, 8'h33};
    tick(1);
    done = '0;
    chk("t1_gpo", gpio_out, 32'h0011_02A5);

    wr(4'd1, 27'h3);
    tick(4);
    wr(4'd14, 27'h0);
    wait_en(seen);
    chk("t2_en", 32'(seen), 32'h1);
    wr(4'd0, 27'd0);
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      tick(1);
    end
    chk("t2_busy_len", 32'(nb), 32'd16);
    chk("t2_gpo", gpio_out, 32'h0012_0100);

    wr(4'd9, 27'h7);
    tick(4);
    wr(4'd14, 27'h0);
    np = 0;
    repeat (6) begin
      tick(1);
      if (en != '0) np++;
    end
    chk("t3_bad_no_en", 32'(np), 32'd0);
    chk("t3_bad_res", 32'(gpio_out[17:16]), 32'd3);
    wr(4'd0, 27'd0);
    tick(4);
    wr(4'd14, 27'h0);
    tick(6);
    chk("t3_noop_res", 32'(gpio_out[17:16]), 32'd0);
    wr(4'd0, 27'd0);
    tick(3);

    wr(4'd3, 27'h1234);
    tick(4);
    wr(4'd14, 27'h0);
    np = 0;
    repeat (50) begin
      tick(1);
      if (en != '0) np++;
    end
    chk("t4_hold_once", 32'(np), 32'd1);
    chk("t4_no_ovr", 32'(gpio_out[19]), 32'd0);
    wr(4'd4, 27'h9);
    tick(4);
    wr(4'd14, 27'h0);
    wait_en(seen);
    chk("t4_en", 32'(seen), 32'h8);
    wr(4'd4, 27'h9);
    tick(3);
    wr(4'd14, 27'h0);
    np = 0;
    repeat (4) begin
      tick(1);
      if (en != '0) np++;
    end
    chk("t4_ignored", 32'(np), 32'd0);
    chk("t4_ovr", 32'(gpio_out[19]), 32'd1);
    wr(4'd0, 27'd0);
    tick(20);
    chk("t4_ovr_sticky", 32'(gpio_out[19]), 32'd1);

    wr(4'd2, 27'h1);
    tick(4);
    wr(4'd14, 27'h0);
    wait_en(seen);
    wr(4'd0, 27'd0);
    tick(3);
    gpio_in = 32'h8000_0000;
    tick(3);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_gpo", 32'(gpio_out[27:16]), 32'd0);
    gpio_in = 32'h0;
    done = 4'b0010;
    cb   = '1;
    tick(1);
    done = '0;
    tick(3);
    chk("t5_late", 32'(gpio_out[27:0]), 32'd0);

    for (int i = 0; i < 256; i++) begin
      c = $urandom_range(1, N);
      wr(4'(c), 27'($urandom));
      tick(3);
      wr(4'd14, 27'h0);
      wait_en(seen);
      chk("t6_en", 32'(seen), 32'(1 << (c - 1)));
      wr(4'd0, 27'd0);
      tick($urandom_range(1, 5));
      done = 4'(1 << (c - 1));
      cb   = $urandom;
      tick(1);
      done = '0;
      tick(1);
    end
    chk("t6_wrap", 32'(gpio_out[27:16]), 32'h001);

    for (int it = 0; it < 300; it++) begin
      nb = $urandom_range(0, 99);
      if (nb < 5) begin
        gpio_in = {1'b1, 31'($urandom)};
        rtick($urandom_range(1, 3));
        wr(4'd0, 27'd0);
        rtick(2);
      end else begin
        c = (nb < 70) ? $urandom_range(1, N)
                      : $urandom_range(0, 15);
        if (c == 14) c = 0;
        wr(4'(c), 27'($urandom));
        rtick($urandom_range(1, 4));
        wr(4'd14, 27'($urandom));
        rtick($urandom_range(1, 4));
        wr(4'($urandom_range(0, 13)), 27'($urandom));
        rtick($urandom_range(0, 20));
      end
    end
    done = '0;
    tick(T + 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
